// File: rtl/super_pkg.sv
// Shared front-end types.
//   ir_reg_t       : decompressed, predicted instruction handed from IF onward
//   IqDepthDefault : default instruction-queue depth
//   iq_cnt_t       : occupancy counter type sized for the default depth
`timescale 1ns/1ps
package super_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic        is_rvc;
    } ir_reg_t;

    localparam int unsigned IqDepthDefault = 4;
    localparam int unsigned IqCntWDefault  = $clog2(IqDepthDefault + 1);

    typedef logic [IqCntWDefault-1:0] iq_cnt_t;

endpackage

// File: rtl/ds_instr_queue.sv
// Dual-issue instruction queue between fetch and decode/issue.
// Accepts up to two instructions per cycle from IF, presents up to two
// in-order instructions per cycle to decode, and is emptied by a PC redirect.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   if_valid_i[1:0]        IF valid (00/01/11; 10 is illegal and treated as 00)
//   if_instr0_i/1_i        older/younger IF instruction
//   ds_rdy_o[1:0]          ready to IF: bit0 >=1 free entry, bit1 >=2 free
//   flush_i                PC redirect: drop contents and this cycle's traffic
//   iq_valid_o[1:0]        head / head+1 valid
//   iq_instr0_o/1_o        head / head+1 instruction
//   issue_rdy_i[1:0]       decode consumes; bit1 only counts with bit0
//   iq_count_o             registered occupancy
//
// Build option: define IQ_BYPASS_EN to forward pushes straight to the
// outputs when the queue is empty (zero-cycle latency). ds_rdy_o stays
// registered-only in both builds.
`timescale 1ns/1ps
module ds_instr_queue
    import super_pkg::*;
#(
    parameter  int unsigned Depth = IqDepthDefault,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0]      if_valid_i,
    input  ir_reg_t         if_instr0_i,
    input  ir_reg_t         if_instr1_i,
    output logic [1:0]      ds_rdy_o,
    input  logic            flush_i,
    output logic [1:0]      iq_valid_o,
    output ir_reg_t         iq_instr0_o,
    output ir_reg_t         iq_instr1_o,
    input  logic [1:0]      issue_rdy_i,
    output logic [CntW-1:0] iq_count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    ir_reg_t         mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [1:0]      ds_rdy_q, ds_rdy_d;

    logic            push0, push1, pop0, pop1;
    logic [1:0]      npush, npop;
    logic            bypass_act;
    logic [1:0]      iq_valid_c;
    ir_reg_t         head0_c, head1_c;
    logic            we0, we1;
    ir_reg_t         wdata0, wdata1;

    // Free-slot decode; only ever applied to the next registered count.
    function automatic logic [1:0] rdy_decode(input logic [CntW-1:0] cnt);
        rdy_decode = {cnt <= CntW'(Depth - 2), cnt <= CntW'(Depth - 1)};
    endfunction

    // Handshakes, output selection and next-state computation.
    always_comb begin
        push0 = if_valid_i[0] & ds_rdy_q[0];
        push1 = if_valid_i[1] & ds_rdy_q[1] & push0;
        npush = {1'b0, push0} + {1'b0, push1};

        bypass_act = 1'b0;
        iq_valid_c = {count_q >= CntW'(2), count_q >= CntW'(1)};
        head0_c    = mem_q[rd_ptr_q];
        head1_c    = mem_q[rd_ptr_q + PtrW'(1)];
`ifdef IQ_BYPASS_EN
        // Empty queue: show this cycle's pushes directly.
        if ((count_q == '0) && !flush_i) begin
            bypass_act = 1'b1;
            iq_valid_c = {push1, push0};
            head0_c    = if_instr0_i;
            head1_c    = if_instr1_i;
        end
`endif

        pop0 = iq_valid_c[0] & issue_rdy_i[0];
        pop1 = iq_valid_c[1] & issue_rdy_i[1] & pop0;
        npop = {1'b0, pop0} + {1'b0, pop1};

        we0      = push0;
        we1      = push1;
        wdata0   = if_instr0_i;
        wdata1   = if_instr1_i;
        wr_ptr_d = wr_ptr_q + PtrW'(npush);
        rd_ptr_d = rd_ptr_q + PtrW'(npop);
        count_d  = count_q + CntW'(npush) - CntW'(npop);

        // Bypassed instructions that decode took are never stored; the
        // survivor (if any) lands at wr_ptr, which equals rd_ptr when empty.
        if (bypass_act) begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q + PtrW'(npush - npop);
            if (pop0) begin
                we0    = push1 & ~pop1;
                wdata0 = if_instr1_i;
                we1    = 1'b0;
            end
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            we0      = 1'b0;
            we1      = 1'b0;
        end

        ds_rdy_d = rdy_decode(count_d);
    end

    // Pointer / occupancy / ready registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ds_rdy_q <= 2'b11;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ds_rdy_q <= ds_rdy_d;
            assert (if_valid_i != 2'b10)
            else $warning("ds_instr_queue: if_valid_i=10 is not a legal pattern, treated as 00");
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (we0) mem_q[wr_ptr_q] <= wdata0;
        if (we1) mem_q[wr_ptr_q + PtrW'(1)] <= wdata1;
    end

    assign ds_rdy_o    = ds_rdy_q;
    assign iq_valid_o  = iq_valid_c;
    assign iq_instr0_o = head0_c;
    assign iq_instr1_o = head1_c;
    assign iq_count_o  = count_q;

endmodule

// File: tb/tb_ds_instr_queue.sv
// Directed bench for ds_instr_queue (Depth=4): fill/full, one-free-slot,
// pointer wrap under simultaneous push/pop, flush priority, illegal
// handshake patterns, empty-queue behaviour (with/without IQ_BYPASS_EN),
// and reset overriding traffic.
`timescale 1ns/1ps
module tb_ds_instr_queue;
    import super_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] if_valid;
    ir_reg_t    if_i0, if_i1;
    logic [1:0] ds_rdy;
    logic       flush;
    logic [1:0] iq_valid;
    ir_reg_t    iq_i0, iq_i1;
    logic [1:0] issue_rdy;
    logic [2:0] iq_count;

    int checks = 0;
    int errors = 0;

    ds_instr_queue #(.Depth(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_valid_i  (if_valid),
        .if_instr0_i (if_i0),
        .if_instr1_i (if_i1),
        .ds_rdy_o    (ds_rdy),
        .flush_i     (flush),
        .iq_valid_o  (iq_valid),
        .iq_instr0_o (iq_i0),
        .iq_instr1_o (iq_i1),
        .issue_rdy_i (issue_rdy),
        .iq_count_o  (iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ir_reg_t mk(input int unsigned id);
        ir_reg_t r;
        r.pc         = 32'h1000 + 32'(id * 4);
        r.instr      = 32'hC0DE_0000 | 32'(id);
        r.pred_taken = id[0];
        r.is_rvc     = id[1];
        return r;
    endfunction

    task automatic chk_cnt(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_ir(input string tag, input ir_reg_t obs, input ir_reg_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [1:0] v, input int unsigned a, input int unsigned b,
                       input logic [1:0] iss, input logic fl);
        if_valid  = v;
        if_i0     = mk(a);
        if_i1     = mk(b);
        issue_rdy = iss;
        flush     = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drv(2'b00, 0, 0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cnt("rst_count", iq_count, 3'd0);
        chk2("rst_valid", iq_valid, 2'b00);
        chk2("rst_rdy", ds_rdy, 2'b11);

        // Fill with two pairs, decode stalled.
        drv(2'b11, 0, 1, 2'b00, 1'b0); tick;
        chk_cnt("fill1_count", iq_count, 3'd2);
        chk2("fill1_rdy", ds_rdy, 2'b11);
        drv(2'b11, 2, 3, 2'b00, 1'b0); tick;
        chk_cnt("full_count", iq_count, 3'd4);
        chk2("full_rdy", ds_rdy, 2'b00);
        chk2("full_valid", iq_valid, 2'b11);
        chk_ir("full_head0", iq_i0, mk(0));
        chk_ir("full_head1", iq_i1, mk(1));

        // Full: IF valid ignored.
        drv(2'b11, 4, 5, 2'b00, 1'b0); tick;
        chk_cnt("full_ignore_count", iq_count, 3'd4);
        chk_ir("full_ignore_head0", iq_i0, mk(0));

        // Pop one -> one free slot.
        drv(2'b00, 0, 0, 2'b01, 1'b0); tick;
        chk_cnt("pop1_count", iq_count, 3'd3);
        chk2("one_free_rdy", ds_rdy, 2'b01);
        chk_ir("pop1_head0", iq_i0, mk(1));
        chk_ir("pop1_head1", iq_i1, mk(2));

        // Only instr0 (id4) accepted; IF keeps id5.
        drv(2'b11, 4, 5, 2'b00, 1'b0); tick;
        chk_cnt("partial_count", iq_count, 3'd4);
        chk2("partial_rdy", ds_rdy, 2'b00);

        // IF re-presents id5 while full and decode takes two.
        drv(2'b01, 5, 0, 2'b11, 1'b0); tick;
        chk_cnt("pop2_count", iq_count, 3'd2);
        chk_ir("pop2_head0", iq_i0, mk(3));
        chk_ir("pop2_head1", iq_i1, mk(4));
        drv(2'b01, 5, 0, 2'b00, 1'b0); tick;
        chk_cnt("reissue_count", iq_count, 3'd3);

        // Pop one; rd_ptr wraps 3 -> 0.
        drv(2'b00, 0, 0, 2'b01, 1'b0); tick;
        chk_cnt("wrap_pop_count", iq_count, 3'd2);
        chk_ir("wrap_pop_head0", iq_i0, mk(4));
        chk_ir("wrap_pop_head1", iq_i1, mk(5));

        // Simultaneous push 2 / pop 2: wr_ptr wraps, then rd_ptr wraps.
        drv(2'b11, 6, 7, 2'b11, 1'b0); tick;
        chk_cnt("pushpop1_count", iq_count, 3'd2);
        chk_ir("pushpop1_head0", iq_i0, mk(6));
        chk_ir("pushpop1_head1", iq_i1, mk(7));
        drv(2'b11, 8, 9, 2'b11, 1'b0); tick;
        chk_cnt("pushpop2_count", iq_count, 3'd2);
        chk_ir("pushpop2_head0", iq_i0, mk(8));
        chk_ir("pushpop2_head1", iq_i1, mk(9));

        // issue_rdy=10: no pop.
        drv(2'b00, 0, 0, 2'b10, 1'b0); tick;
        chk_cnt("iss10_count", iq_count, 3'd2);
        chk_ir("iss10_head0", iq_i0, mk(8));

        // if_valid=10: illegal, no push.
        drv(2'b10, 20, 21, 2'b00, 1'b0); tick;
        chk_cnt("ifv10_count", iq_count, 3'd2);
        chk_ir("ifv10_head1", iq_i1, mk(9));

        drv(2'b01, 10, 0, 2'b00, 1'b0); tick;
        chk_cnt("pre_flush_count", iq_count, 3'd3);

        // Flush beats push and pop.
        drv(2'b11, 11, 12, 2'b11, 1'b1); tick;
        chk_cnt("flush_count", iq_count, 3'd0);
        chk2("flush_valid", iq_valid, 2'b00);
        chk2("flush_rdy", ds_rdy, 2'b11);

        drv(2'b11, 13, 14, 2'b00, 1'b0); tick;
        chk_cnt("post_flush_count", iq_count, 3'd2);
        chk_ir("post_flush_head0", iq_i0, mk(13));
        chk_ir("post_flush_head1", iq_i1, mk(14));

        drv(2'b00, 0, 0, 2'b11, 1'b0); tick;
        chk_cnt("drain_count", iq_count, 3'd0);
        chk2("drain_valid", iq_valid, 2'b00);

        // Empty: issue_rdy ignored.
        drv(2'b00, 0, 0, 2'b11, 1'b0); tick;
        chk_cnt("empty_pop_count", iq_count, 3'd0);

        // Empty queue, push pair, decode takes one.
        drv(2'b11, 15, 16, 2'b01, 1'b0);
        #1;
`ifdef IQ_BYPASS_EN
        chk2("byp_same_valid", iq_valid, 2'b11);
        chk_ir("byp_same_head0", iq_i0, mk(15));
`else
        chk2("nobyp_same_valid", iq_valid, 2'b00);
`endif
        tick;
`ifdef IQ_BYPASS_EN
        chk_cnt("byp_next_count", iq_count, 3'd1);
        chk2("byp_next_valid", iq_valid, 2'b01);
        chk_ir("byp_next_head0", iq_i0, mk(16));
`else
        chk_cnt("nobyp_next_count", iq_count, 3'd2);
        chk_ir("nobyp_next_head0", iq_i0, mk(15));
        chk_ir("nobyp_next_head1", iq_i1, mk(16));
`endif

        // Reset mid-operation overrides flush and traffic.
        drv(2'b11, 17, 18, 2'b11, 1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        drv(2'b00, 0, 0, 2'b00, 1'b0);
        chk_cnt("midrst_count", iq_count, 3'd0);
        chk2("midrst_valid", iq_valid, 2'b00);
        chk2("midrst_rdy", ds_rdy, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
